// File: rtl/mem_stage_dm_if.sv
// mem_stage_dm_if: MEM-stage data-memory bus between the EX/MEM register and the data memory.
//   ins_M        instruction in MEM; [31:26] is the opcode
//   pc_M         PC of ins_M (only used by the store log)
//   alu_Result_M byte address
//   RData2_M     forwarded store data
//   DMRData_M    extended load result, captured by MEM/WB
//   misalign_M   misaligned load/store in MEM this cycle
// master: pipeline side driving the request; slave: data memory unit.
interface mem_stage_dm_if;
    logic [31:0] ins_M;
    logic [31:0] pc_M;
    logic [31:0] alu_Result_M;
    logic [31:0] RData2_M;
    logic [31:0] DMRData_M;
    logic        misalign_M;

    modport master (
        output ins_M, pc_M, alu_Result_M, RData2_M,
        input  DMRData_M, misalign_M
    );

    modport slave (
        input  ins_M, pc_M, alu_Result_M, RData2_M,
        output DMRData_M, misalign_M
    );
endinterface

// File: rtl/mem_stage_dm.sv
// mem_stage_dm: MEM-stage data memory with byte/half/word stores and extended loads.
//   clk  posedge clock
//   rst  synchronous active-high reset; clears the whole array, beats a concurrent store
//   bus  mem_stage_dm_if.slave (ins_M, pc_M, alu_Result_M, RData2_M in; DMRData_M, misalign_M out)
// Loads read the array combinationally; stores commit on the next posedge.
// Misaligned accesses raise misalign_M; misaligned stores are dropped, misaligned loads return 0.
// Optional macro DM_WRITE_LOG_EN: simulation-only log line for every performed store.
module mem_stage_dm #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input logic           clk,
    input logic           rst,
    mem_stage_dm_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSw  = 6'h2B;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    logic [31:0]           mem_q [Depth];
    logic [31:0]           mem_wdata_d;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_off;
    logic [5:0]            opcode;
    logic                  is_load;
    logic                  is_store;
    logic                  sign_ext;
    size_e                 size;
    logic                  misalign;
    logic                  wr_en;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_data;

    // Upper address bits wrap; low instruction bits and the PC carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.ins_M[25:0], bus.pc_M, bus.alu_Result_M[31:ADDR_WIDTH+2]};

    assign opcode   = bus.ins_M[31:26];
    assign word_idx = bus.alu_Result_M[ADDR_WIDTH+1:2];
    assign byte_off = bus.alu_Result_M[1:0];
    assign rd_word  = mem_q[word_idx];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = SzWord;
        case (opcode)
            OpLw:    begin is_load = 1'b1; size = SzWord; end
            OpLb:    begin is_load = 1'b1; size = SzByte; sign_ext = 1'b1; end
            OpLbu:   begin is_load = 1'b1; size = SzByte; end
            OpLh:    begin is_load = 1'b1; size = SzHalf; sign_ext = 1'b1; end
            OpLhu:   begin is_load = 1'b1; size = SzHalf; end
            OpSw:    begin is_store = 1'b1; size = SzWord; end
            OpSb:    begin is_store = 1'b1; size = SzByte; end
            OpSh:    begin is_store = 1'b1; size = SzHalf; end
            default: ;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        if (is_load || is_store) begin
            case (size)
                SzWord:  misalign = (byte_off != 2'b00);
                SzHalf:  misalign = byte_off[0];
                default: misalign = 1'b0;
            endcase
        end
    end

    assign wr_en = is_store && !misalign;

    // Merge the store data into the current word so untouched lanes are preserved.
    always_comb begin
        mem_wdata_d = rd_word;
        case (size)
            SzWord: mem_wdata_d = bus.RData2_M;
            SzHalf: begin
                if (byte_off[1]) mem_wdata_d[31:16] = bus.RData2_M[15:0];
                else             mem_wdata_d[15:0]  = bus.RData2_M[15:0];
            end
            default: mem_wdata_d[{byte_off, 3'b000} +: 8] = bus.RData2_M[7:0];
        endcase
    end

    assign rd_byte = rd_word[{byte_off, 3'b000} +: 8];
    assign rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'h0;
        if (is_load && !misalign) begin
            case (size)
                SzByte:  load_data = {{24{sign_ext & rd_byte[7]}}, rd_byte};
                SzHalf:  load_data = {{16{sign_ext & rd_half[15]}}, rd_half};
                default: load_data = rd_word;
            endcase
        end
    end

    assign bus.DMRData_M  = load_data;
    assign bus.misalign_M = misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i[ADDR_WIDTH-1:0]] <= 32'h0;
            end
        end else if (wr_en) begin
            mem_q[word_idx] <= mem_wdata_d;
        end
    end

`ifdef DM_WRITE_LOG_EN
    always @(posedge clk) begin
        if (!rst && wr_en) begin
            $display("%d@%h: *%h <= %h", $time, bus.pc_M, {bus.alu_Result_M[31:2], 2'b00},
                     mem_wdata_d);
        end
    end
`else
`endif

endmodule

// File: tb/tb_mem_stage_dm.sv
module tb_mem_stage_dm;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] NOP = 6'h00;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_d;
        logic        exp_m;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] pc = 32'h0040_0000;
    vec_t vecs[$];

    mem_stage_dm_if bus ();

    mem_stage_dm #(.ADDR_WIDTH(10)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic c, input logic [31:0] ed,
                       input logic em);
        vec_t v;
        v.rst = r; v.op = op; v.addr = a; v.wdata = d; v.chk = c; v.exp_d = ed; v.exp_m = em;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; stores commit on the following rising edge.
    task automatic drive(input logic r, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        rst              = r;
        bus.ins_M        = {op, 26'h0155};
        bus.pc_M         = pc;
        bus.alu_Result_M = a;
        bus.RData2_M     = d;
        pc               = pc + 32'd4;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    initial begin
        // reset and empty reads
        add(1, LW,  32'h000, 32'h0,        0, 32'h0,        0);
        add(0, LW,  32'h000, 32'h0,        1, 32'h0,        0);
        add(0, LW,  32'hFFC, 32'h0,        1, 32'h0,        0);
        // word store then reads
        add(0, SW,  32'h010, 32'h8badf00d, 1, 32'h0,        0);
        add(0, LW,  32'h010, 32'h0,        1, 32'h8badf00d, 0);
        add(0, LB,  32'h013, 32'h0,        1, 32'hffffff8b, 0);
        add(0, LBU, 32'h013, 32'h0,        1, 32'h0000008b, 0);
        // lane-masked stores
        add(0, SB,  32'h011, 32'h000000AA, 1, 32'h0,        0);
        add(0, LW,  32'h010, 32'h0,        1, 32'h8badaa0d, 0);
        add(0, SH,  32'h012, 32'h00001234, 1, 32'h0,        0);
        add(0, LW,  32'h010, 32'h0,        1, 32'h1234aa0d, 0);
        add(0, LH,  32'h010, 32'h0,        1, 32'hffffaa0d, 0);
        add(0, LHU, 32'h012, 32'h0,        1, 32'h00001234, 0);
        add(0, LH,  32'h012, 32'h0,        1, 32'h00001234, 0);
        add(0, LB,  32'h010, 32'h0,        1, 32'h0000000d, 0);
        add(0, LB,  32'h011, 32'h0,        1, 32'hffffffaa, 0);
        // misaligned accesses
        add(0, SW,  32'h016, 32'hdeadbeef, 1, 32'h0,        1);
        add(0, SH,  32'h015, 32'h0000ffff, 1, 32'h0,        1);
        add(0, LW,  32'h010, 32'h0,        1, 32'h1234aa0d, 0);
        add(0, LW,  32'h012, 32'h0,        1, 32'h0,        1);
        add(0, LH,  32'h011, 32'h0,        1, 32'h0,        1);
        add(0, NOP, 32'h013, 32'h0,        1, 32'h0,        0);
        // wrap-around
        add(0, SW,  32'h1000, 32'h11111111, 1, 32'h0,       0);
        add(0, LW,  32'h000, 32'h0,        1, 32'h11111111, 0);
        // store concurrent with reset is discarded, array cleared
        add(1, SW,  32'h020, 32'h22222222, 1, 32'h0,        0);
        add(0, LW,  32'h020, 32'h0,        1, 32'h0,        0);
        add(0, LW,  32'h010, 32'h0,        1, 32'h0,        0);
        add(0, LW,  32'h000, 32'h0,        1, 32'h0,        0);
        // repeated byte store, then half over the top lane
        add(0, SB,  32'h003, 32'h00000055, 1, 32'h0,        0);
        add(0, SB,  32'h003, 32'h00000055, 1, 32'h0,        0);
        add(0, LW,  32'h000, 32'h0,        1, 32'h55000000, 0);
        add(0, LBU, 32'h003, 32'h0,        1, 32'h00000055, 0);
        add(0, SH,  32'h002, 32'h00008000, 1, 32'h0,        0);
        add(0, LH,  32'h002, 32'h0,        1, 32'hffff8000, 0);
        add(0, LW,  32'h000, 32'h0,        1, 32'h80000000, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d data", i), bus.DMRData_M, vecs[i].exp_d);
                check($sformatf("vec%0d misalign", i), {31'h0, bus.misalign_M},
                      {31'h0, vecs[i].exp_m});
            end
        end

        // Stalled store held for three cycles with the same instruction
        pc = 32'h0040_1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst              = 1'b0;
            bus.ins_M        = {SW, 26'h0155};
            bus.pc_M         = pc;
            bus.alu_Result_M = 32'h3FC;
            bus.RData2_M     = 32'hcafef00d;
            #1;
            check("stall sw misalign", {31'h0, bus.misalign_M}, 32'h0);
        end
        drive(0, LW, 32'h3FC, 32'h0);
        check("stall lw", bus.DMRData_M, 32'hcafef00d);
        drive(0, LW, 32'h13FC, 32'h0);
        check("wrap lw", bus.DMRData_M, 32'hcafef00d);
        drive(0, LBU, 32'h3FF, 32'h0);
        check("stall lbu", bus.DMRData_M, 32'h000000ca);
        drive(0, LHU, 32'h3FD, 32'h0);
        check("lhu odd data", bus.DMRData_M, 32'h0);
        check("lhu odd misalign", {31'h0, bus.misalign_M}, 32'h1);
        // Misaligned store followed by reads of both halves: nothing changed
        drive(0, SH, 32'h3FF, 32'h0000beef);
        check("sh odd misalign", {31'h0, bus.misalign_M}, 32'h1);
        drive(0, LW, 32'h3FC, 32'h0);
        check("after bad sh", bus.DMRData_M, 32'hcafef00d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
